exp3_unidade_controle: RTL and testbench

EXP3_UNIDADE_CONTROLE -- requirements
Module: exp3_unidade_controle

---
 rtl/exp3_unidade_controle.sv | 201 ++++++++++++++++++++
 tb/tb_exp3_unidade_controle.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp3_unidade_controle.sv
// exp3_unidade_controle
// Control unit for the memory-matching game round: the player confirms one
// switch value per jogada rising edge, and the datapath compares it against
// 16 ROM words in sequence. The round ends on the first mismatch
// (fim_errou) or after all 16 words match (fim_acertou).
//
// Structure:
//   - A one-flop edge detector on jogada. A held level only acts once.
//   - A Moore FSM. Its next state is computed combinationally.
//   - Output flops loaded with the decode of the next state. Each output
//     flop therefore always equals the decode of the current state
//     register, so the outputs depend only on the state and are glitch-free.
//   - Reset is synchronous and active-high. It forces the state to inicial,
//     the outputs to 0 and the edge-detector flop to 0.

module exp3_unidade_controle (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       chavesIgualMemoria,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic [3:0] db_estado
);

   // State codes are visible on db_estado, so they are fixed values rather
   // than tool-chosen encodings.
   typedef enum logic [3:0] {
      st_inicial     = 4'b0000,
      st_preparacao  = 4'b0001,
      st_espera      = 4'b0010,
      st_registra    = 4'b0100,
      st_compara     = 4'b0101,
      st_proximo     = 4'b0110,
      st_fim_acertou = 4'b1010,
      st_fim_errou   = 4'b1110
   } estado_t;

   estado_t estado_q;
   estado_t estado_d;

   logic    jogada_reg_q;
   logic    jogada_reg_d;
   logic    jogada_pulso;

   logic    zera_c_q;
   logic    zera_c_d;
   logic    conta_c_q;
   logic    conta_c_d;
   logic    zera_r_q;
   logic    zera_r_d;
   logic    registra_r_q;
   logic    registra_r_d;
   logic    pronto_q;
   logic    pronto_d;
   logic    acertou_q;
   logic    acertou_d;
   logic    errou_q;
   logic    errou_d;

   // Edge detector: remember last cycle's jogada and fire only on 0->1.
   always_comb begin
      jogada_reg_d = jogada;
      jogada_pulso = jogada & ~jogada_reg_q;
   end

   // Next-state logic. iniciar only matters in the resting states, and
   // jogada_pulso only matters in espera. Unknown codes fall back to inicial.
   always_comb begin
      estado_d = st_inicial;
      case (estado_q)
         st_inicial: begin
            if (iniciar) begin
               estado_d = st_preparacao;
            end else begin
               estado_d = st_inicial;
            end
         end
         st_preparacao: begin
            estado_d = st_espera;
         end
         st_espera: begin
            if (jogada_pulso) begin
               estado_d = st_registra;
            end else begin
               estado_d = st_espera;
            end
         end
         st_registra: begin
            estado_d = st_compara;
         end
         st_compara: begin
            if (!chavesIgualMemoria) begin
               estado_d = st_fim_errou;
            end else if (fimC) begin
               estado_d = st_fim_acertou;
            end else begin
               estado_d = st_proximo;
            end
         end
         st_proximo: begin
            estado_d = st_espera;
         end
         st_fim_acertou: begin
            if (iniciar) begin
               estado_d = st_preparacao;
            end else begin
               estado_d = st_fim_acertou;
            end
         end
         st_fim_errou: begin
            if (iniciar) begin
               estado_d = st_preparacao;
            end else begin
               estado_d = st_fim_errou;
            end
         end
         default: begin
            estado_d = st_inicial;
         end
      endcase
   end

   // Output decode of the state being entered. The result is registered
   // alongside the state so the outputs line up with the state register.
   always_comb begin
      zera_c_d     = 1'b0;
      conta_c_d    = 1'b0;
      zera_r_d     = 1'b0;
      registra_r_d = 1'b0;
      pronto_d     = 1'b0;
      acertou_d    = 1'b0;
      errou_d      = 1'b0;
      case (estado_d)
         st_preparacao: begin
            zera_c_d = 1'b1;
            zera_r_d = 1'b1;
         end
         st_registra: begin
            registra_r_d = 1'b1;
         end
         st_proximo: begin
            conta_c_d = 1'b1;
         end
         st_fim_acertou: begin
            pronto_d  = 1'b1;
            acertou_d = 1'b1;
         end
         st_fim_errou: begin
            pronto_d = 1'b1;
            errou_d  = 1'b1;
         end
         default: begin
            zera_c_d = 1'b0;
         end
      endcase
   end

   // State, edge-detector and output registers. Synchronous reset has
   // priority over every other input.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q     <= st_inicial;
         jogada_reg_q <= 1'b0;
         zera_c_q     <= 1'b0;
         conta_c_q    <= 1'b0;
         zera_r_q     <= 1'b0;
         registra_r_q <= 1'b0;
         pronto_q     <= 1'b0;
         acertou_q    <= 1'b0;
         errou_q      <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         jogada_reg_q <= jogada_reg_d;
         zera_c_q     <= zera_c_d;
         conta_c_q    <= conta_c_d;
         zera_r_q     <= zera_r_d;
         registra_r_q <= registra_r_d;
         pronto_q     <= pronto_d;
         acertou_q    <= acertou_d;
         errou_q      <= errou_d;
      end
   end

   assign zeraC     = zera_c_q;
   assign contaC    = conta_c_q;
   assign zeraR     = zera_r_q;
   assign registraR = registra_r_q;
   assign pronto    = pronto_q;
   assign acertou   = acertou_q;
   assign errou     = errou_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_exp3_unidade_controle.sv
// Testbench for exp3_unidade_controle.
// Directed game scenarios plus a randomized stretch, all checked every
// cycle against a round-level reference model built from a schedule queue.

module tb_exp3_unidade_controle;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       jogada;
   logic       chavesIgualMemoria;
   logic       fimC;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic [3:0] db_estado;

   int vectors;
   int miscompares;
   int countConta;
   int countRegistra;

   localparam logic [3:0] C_INICIAL  = 4'b0000;
   localparam logic [3:0] C_PREP     = 4'b0001;
   localparam logic [3:0] C_ESPERA   = 4'b0010;
   localparam logic [3:0] C_REGISTRA = 4'b0100;
   localparam logic [3:0] C_COMPARA  = 4'b0101;
   localparam logic [3:0] C_PROXIMO  = 4'b0110;
   localparam logic [3:0] C_FIM_OK   = 4'b1010;
   localparam logic [3:0] C_FIM_ERR  = 4'b1110;

   // The reference model tracks the phase the game is in.
   // Transient phases that follow unconditionally are queued ahead of time.
   logic [3:0] mCur;
   logic       mPrevJog;
   logic [3:0] mSched[$];

   exp3_unidade_controle dut (
      .clock              (clock),
      .reset              (reset),
      .iniciar            (iniciar),
      .jogada             (jogada),
      .chavesIgualMemoria (chavesIgualMemoria),
      .fimC               (fimC),
      .zeraC              (zeraC),
      .contaC             (contaC),
      .zeraR              (zeraR),
      .registraR          (registraR),
      .pronto             (pronto),
      .acertou            (acertou),
      .errou              (errou),
      .db_estado          (db_estado)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at time %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one clock edge with the same inputs the DUT saw.
   task automatic modelEdge(input logic rst, input logic ini, input logic jog, input logic igual, input logic fim);
      logic pulse;
      if (rst) begin
         mCur     = C_INICIAL;
         mPrevJog = 1'b0;
         mSched.delete();
         return;
      end
      pulse    = jog && !mPrevJog;
      mPrevJog = jog;
      if (mSched.size() > 0) begin
         mCur = mSched.pop_front();
      end else if (mCur == C_COMPARA) begin
         if (!igual) begin
            mCur = C_FIM_ERR;
         end else if (fim) begin
            mCur = C_FIM_OK;
         end else begin
            mCur = C_PROXIMO;
            mSched.push_back(C_ESPERA);
         end
      end else if ((mCur == C_INICIAL || mCur == C_FIM_OK || mCur == C_FIM_ERR) && ini) begin
         mCur = C_PREP;
         mSched.push_back(C_ESPERA);
      end else if (mCur == C_ESPERA && pulse) begin
         mCur = C_REGISTRA;
         mSched.push_back(C_COMPARA);
      end
   endtask

   function automatic logic [6:0] expectedOutputs(input logic [3:0] ph);
      logic [6:0] v;
      v[6] = (ph == C_PREP);
      v[5] = (ph == C_PROXIMO);
      v[4] = (ph == C_PREP);
      v[3] = (ph == C_REGISTRA);
      v[2] = (ph == C_FIM_OK) || (ph == C_FIM_ERR);
      v[1] = (ph == C_FIM_OK);
      v[0] = (ph == C_FIM_ERR);
      return v;
   endfunction

   // Drive one cycle of inputs, step the model and compare after the edge.
   task automatic applyStimulus(input logic rst, input logic ini, input logic jog, input logic igual, input logic fim);
      reset              = rst;
      iniciar            = ini;
      jogada             = jog;
      chavesIgualMemoria = igual;
      fimC               = fim;
      @(posedge clock);
      modelEdge(rst, ini, jog, igual, fim);
      #1;
      checkOutput("estado", {28'd0, db_estado}, {28'd0, mCur});
      checkOutput("saidas", {25'd0, zeraC, contaC, zeraR, registraR, pronto, acertou, errou},
                  {25'd0, expectedOutputs(mCur)});
      if (contaC === 1'b1) countConta++;
      if (registraR === 1'b1) countRegistra++;
   endtask

   // One player confirmation. jogada is high for 1..3 cycles and the press
   // lasts at least 4 cycles, so the decision finishes before the next
   // press. iniciar noise is applied only while it must be ignored.
   task automatic pressJogada(input logic igual, input logic fim);
      int h;
      int g;
      h = $urandom_range(1, 3);
      g = $urandom_range(1, 3);
      if (h + g < 4) g = 4 - h;
      for (int i = 0; i < h + g; i++) begin
         applyStimulus(1'b0, (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0, (i < h), igual, fim);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      countConta    = 0;
      countRegistra = 0;
      mCur          = C_INICIAL;
      mPrevJog      = 1'b0;
      reset              = 1'b1;
      iniciar            = 1'b0;
      jogada             = 1'b0;
      chavesIgualMemoria = 1'b0;
      fimC               = 1'b0;

      // Reset for two cycles, then idle with iniciar low.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("reset_estado", {28'd0, db_estado}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      checkOutput("idle_estado", {28'd0, db_estado}, 32'd0);

      // Start: one cycle of preparacao, then espera.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("start_zeras", {30'd0, zeraC, zeraR}, 32'd3);
      checkOutput("start_prep", {28'd0, db_estado}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("start_espera", {28'd0, db_estado}, 32'd2);

      // Full win: 16 matches, with fimC raised only on the last word.
      countConta    = 0;
      countRegistra = 0;
      for (int k = 0; k < 16; k++) begin
         pressJogada(1'b1, (k == 15));
      end
      checkOutput("win_contaC", countConta, 32'd15);
      checkOutput("win_registraR", countRegistra, 32'd16);
      checkOutput("win_estado", {28'd0, db_estado}, 32'd10);
      checkOutput("win_flags", {29'd0, pronto, acertou, errou}, 32'd6);

      // New round from fim_acertou; mismatch on the third compare.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      countConta = 0;
      for (int k = 0; k < 3; k++) begin
         pressJogada((k != 2), 1'b0);
      end
      checkOutput("miss_contaC", countConta, 32'd2);
      checkOutput("miss_estado", {28'd0, db_estado}, 32'd14);
      checkOutput("miss_flags", {29'd0, pronto, acertou, errou}, 32'd5);

      // Held jogada: ten cycles high must register only once.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      countRegistra = 0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("held_registraR", countRegistra, 32'd1);
      checkOutput("held_estado", {28'd0, db_estado}, 32'd2);

      // Mid-round reset while in compara, then restart.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("pre_reset_compara", {28'd0, db_estado}, 32'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("reset_in_compara", {28'd0, db_estado}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("restart_prep", {28'd0, db_estado}, 32'd1);

      // Randomized stretch against the model, with occasional resets.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 59) == 0),
                       ($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
